// File: rtl/alu_secuencial.sv
// Sequential ALU: single-cycle add/sub, WIDTH-cycle shift-add multiply and restoring divide.
// Results and flags are registered and change only on the edge that enters DONE.
module alu_secuencial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] resto,
  output logic             busy,
  output logic             done,
  output logic             negativo,
  output logic             cero,
  output logic             acarreo,
  output logic             desbordamiento
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] resto_q, resto_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             neg_q, neg_d;
  logic             cero_q, cero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   add_res, sub_res, mul_sum, div_shift, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  // One iteration of the datapath. hi/lo hold {partial product, multiplier}
  // for mul and {partial remainder, dividend/quotient} for div.
  always_comb begin
    add_res   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    sub_res   = {1'b0, a} - {1'b0, b};
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    if (op_q == OP_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    resto_d = resto_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = opCode;
          b_d   = b;
          hi_d  = '0;
          lo_d  = a;
          cnt_d = '0;
          if (opCode == OP_ADD) begin
            state_d = DONE;
            out_d   = add_res[WIDTH-1:0];
            resto_d = '0;
            carry_d = add_res[WIDTH];
            ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
          end else if (opCode == OP_SUB) begin
            state_d = DONE;
            out_d   = sub_res[WIDTH-1:0];
            resto_d = '0;
            carry_d = ~sub_res[WIDTH];
            ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = lo_n;
          resto_d = (op_q == OP_MUL) ? '0 : hi_n;
          carry_d = (op_q == OP_MUL) ? (|hi_n) : 1'b0;
          // Divide by zero falls out of the restoring loop as quotient all-ones, remainder a.
          ovf_d   = (op_q != OP_MUL) && (b_q == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    neg_d  = out_d[WIDTH-1];
    cero_d = (out_d == '0);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      resto_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      cero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      resto_q <= resto_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      cero_q  <= cero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out            = out_q;
  assign resto          = resto_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign negativo       = neg_q;
  assign cero           = cero_q;
  assign acarreo        = carry_q;
  assign desbordamiento = ovf_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial at WIDTH=4: vector table plus random vectors against an arithmetic model,
// scoreboard queue of expected results, and hand sequences for ignored starts and reset abort.
module tb_alu_secuencial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, ci;
  logic [1:0]   opCode;
  logic [W-1:0] a, b, out, resto;
  logic         busy, done, negativo, cero, acarreo, desbordamiento;

  always #5 clk = ~clk;

  alu_secuencial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opCode(opCode), .a(a), .b(b), .ci(ci),
    .out(out), .resto(resto), .busy(busy), .done(done), .negativo(negativo),
    .cero(cero), .acarreo(acarreo), .desbordamiento(desbordamiento)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] out;
    logic [W-1:0] resto;
    logic [3:0]   flags;  // {negativo, cero, acarreo, desbordamiento}
    int           lat;
  } vec_t;

  vec_t  exp_q[$];
  vec_t  vecs[15];
  int    n_chk  = 0;
  int    n_pass = 0;
  string ctx    = "";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s [%s]: got %0h, expected %0h", name, ctx, act, expv);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input int av, input int bv, input int civ,
                              input int o, input int r, input logic [3:0] f);
    vec_t v;
    v.op = op; v.a = W'(av); v.b = W'(bv); v.ci = civ[0];
    v.out = W'(o); v.resto = W'(r); v.flags = f;
    v.lat = (op[1]) ? W + 1 : 1;
    return v;
  endfunction

  // Reference arithmetic written with integer operators, independent of the bit-serial datapath.
  function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic civ);
    int ua, ub, sa, sb, s, ss, o, r;
    logic c, v;
    ua = int'(av); ub = int'(bv);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    r = 0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        s = ua + ub + int'(civ); o = s % 16; c = (s >= 16);
        ss = sa + sb + int'(civ); v = (ss > 7) || (ss < -8);
      end
      2'b01: begin
        s = ua - ub; o = (s + 16) % 16; c = (ua >= ub);
        ss = sa - sb; v = (ss > 7) || (ss < -8);
      end
      2'b10: begin
        s = ua * ub; o = s % 16; c = (s >= 16);
      end
      default: begin
        if (ub == 0) begin o = 15; r = ua; v = 1'b1; end
        else begin o = ua / ub; r = ua % ub; end
      end
    endcase
    return mk(op, ua, ub, int'(civ), o, r, {o >= 8, o == 0, c, v});
  endfunction

  task automatic run_op(input vec_t v);
    vec_t e;
    int   lat, nb;
    e = v;
    @(negedge clk);
    opCode = v.op; a = v.a; b = v.b; ci = v.ci; start = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom); opCode = 2'($urandom);
    lat = 1; nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    if (busy) nb++;
    check("done_seen", {31'd0, done}, 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("latency", lat, e.lat);
      check("busy_cycles", nb, e.lat);
      check("out", {28'd0, out}, {28'd0, e.out});
      check("resto", {28'd0, resto}, {28'd0, e.resto});
      check("flags", {28'd0, negativo, cero, acarreo, desbordamiento}, {28'd0, e.flags});
    end
    @(negedge clk);
    check("pulse_end", {30'd0, done, busy}, 32'd0);
    check("out_hold", {28'd0, out}, {28'd0, e.out});
  endtask

  initial begin
    int ndone;
    vec_t v;

    vecs[0]  = mk(2'b00,  7, 2, 0,  9, 0, 4'b1001);
    vecs[1]  = mk(2'b00, 13, 3, 0,  0, 0, 4'b0110);
    vecs[2]  = mk(2'b01,  1, 2, 1, 15, 0, 4'b1000);
    vecs[3]  = mk(2'b10,  7, 2, 0, 14, 0, 4'b1000);
    vecs[4]  = mk(2'b11,  7, 2, 0,  3, 1, 4'b0000);
    vecs[5]  = mk(2'b10, 13, 3, 0,  7, 0, 4'b0010);
    vecs[6]  = mk(2'b11, 13, 3, 0,  4, 1, 4'b0000);
    vecs[7]  = mk(2'b11,  5, 0, 0, 15, 5, 4'b1001);
    vecs[8]  = mk(2'b00, 15, 0, 1,  0, 0, 4'b0110);
    vecs[9]  = mk(2'b01,  8, 1, 0,  7, 0, 4'b0011);
    vecs[10] = mk(2'b10, 15, 15, 1, 1, 0, 4'b0010);
    vecs[11] = mk(2'b11, 15, 1, 0, 15, 0, 4'b1000);
    vecs[12] = mk(2'b11,  3, 9, 0,  0, 3, 4'b0100);
    vecs[13] = mk(2'b00,  4, 4, 1,  9, 0, 4'b1001);
    vecs[14] = mk(2'b01,  5, 5, 0,  0, 0, 4'b0110);

    rst = 1'b1; start = 1'b0; opCode = '0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    ctx = "reset";
    check("reset_outputs", {20'd0, out, resto, busy, done, negativo, cero, acarreo, desbordamiento}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_op(vecs[i]);
    end

    for (int i = 0; i < 20; i++) begin
      ctx = $sformatf("rand%0d", i);
      run_op(model(2'($urandom), W'($urandom), W'($urandom), 1'($urandom)));
    end

    // Starts during RUN and DONE must be dropped: exactly one done for the div by zero.
    ctx = "start_ignored";
    @(negedge clk);
    opCode = 2'b11; a = 4'b0101; b = 4'b0000; ci = 1'b0; start = 1'b1;
    exp_q.push_back(model(2'b11, 4'b0101, 4'b0000, 1'b0));
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (exp_q.size() != 0) begin
          v = exp_q.pop_front();
          check("div0_out", {28'd0, out}, {28'd0, v.out});
          check("div0_resto", {28'd0, resto}, {28'd0, v.resto});
          check("div0_flags", {28'd0, negativo, cero, acarreo, desbordamiento}, {28'd0, v.flags});
        end
      end
      start = (i == 2 || i == 5);
      opCode = 2'b00; a = 4'b0001; b = 4'b0001;
    end
    check("single_done", ndone, 1);
    check("queue_drained", exp_q.size(), 0);

    // Reset in the third RUN cycle of a multiply aborts it; rst also beats a concurrent start.
    ctx = "reset_abort";
    run_op(vecs[0]);
    ctx = "reset_abort";
    @(negedge clk);
    opCode = 2'b10; a = 4'b0111; b = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1; start = 1'b1; opCode = 2'b00;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_outputs", {20'd0, out, resto, busy, done, negativo, cero, acarreo, desbordamiento}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    ctx = "after_abort";
    run_op(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_secuencial.md
ALU_SECUENCIAL -- requirements
Module: alu_secuencial

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 opCode  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 a  input  WIDTH  operand A, unsigned for mul/div.
REQ-007 b  input  WIDTH  operand B, unsigned for mul/div.
REQ-008 ci  input  1  carry-in, used by add only.
REQ-009 out  output  WIDTH  result; holds last completed value.
REQ-010 resto  output  WIDTH  div remainder; 0 for other ops.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 negativo, cero, acarreo, desbordamiento  output  1 each  flags of last completed result.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->DONE (add/sub) or IDLE->RUN (mul/div) on edge with start=1; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-015 a, b, ci, opCode latched on accepting edge; later input changes do not affect the operation in flight.
REQ-016 start while busy=1 (RUN or DONE) ignored, not queued.
REQ-017 add: out = (a+b+ci) mod 2^WIDTH; acarreo = carry out of bit WIDTH-1; desbordamiento = signed overflow.
REQ-018 sub: out = (a-b) mod 2^WIDTH; acarreo = 1 when no borrow (a>=b unsigned); desbordamiento = signed overflow; ci ignored.
REQ-019 add/sub latency: done=1 and out/flags valid in the cycle immediately after the accepting edge.
REQ-020 mul: iterative shift-add, one bit per cycle, WIDTH RUN cycles; out = low WIDTH bits of product; acarreo = 1 if high WIDTH bits nonzero; desbordamiento = 0.
REQ-021 div: restoring, one quotient bit per cycle, WIDTH RUN cycles; out = floor(a/b), resto = a mod b; acarreo = 0; desbordamiento = 0.
REQ-022 div with b=0: same latency; out = all ones, resto = a, desbordamiento = 1, acarreo = 0.
REQ-023 mul/div latency: done=1 in cycle WIDTH+1 after the accepting edge.
REQ-024 All ops: negativo = out[WIDTH-1]; cero = (out==0).
REQ-025 out, resto, flags update only on the edge entering DONE; stable otherwise.
REQ-026 done high only in DONE; busy low only in IDLE.

Reset
REQ-027 rst=1 on a rising edge: state IDLE, iteration counter 0, out=0, resto=0, all flags 0, done=0, busy=0.
REQ-028 rst during RUN or DONE aborts the operation; no done pulse issued for it; rst has priority over start in the same cycle.

Verification (WIDTH=4)
REQ-029 a=0111, b=0010, ci=0, add -> one cycle later done=1, out=1001, negativo=1, cero=0, acarreo=0, desbordamiento=1.
REQ-030 a=1101, b=0011, add -> out=0000, cero=1, acarreo=1, desbordamiento=0; sub a=0001, b=0010 -> out=1111, negativo=1, acarreo=0.
REQ-031 a=0111, b=0010, mul -> busy for 5 cycles, done in cycle 5, out=1110, acarreo=0; then div -> out=0011, resto=0001.
REQ-032 a=1101, b=0011, mul -> out=0111, acarreo=1; div -> out=0100, resto=0001.
REQ-033 a=0101, b=0000, div -> out=1111, resto=0101, desbordamiento=1; start pulsed during RUN ignored (exactly one done).
REQ-034 rst asserted in 3rd RUN cycle of mul -> next cycle busy=0, out=0, flags 0, no done; new add afterwards completes normally.
